// File: rtl/fft_bfly_ctrl_if.sv
// Bus between the radix-2 FFT sequencer and its data RAM, twiddle ROM and butterfly unit.
// master is the sequencer side; slave is the memory / butterfly side.
interface fft_bfly_ctrl_if;
   logic        start;
   logic        busy;
   logic        done;

   logic        rd_en;
   logic [7:0]  rd_addr1;
   logic [7:0]  rd_addr2;
   logic [63:0] rd_data1;
   logic [63:0] rd_data2;
   logic [7:0]  tw_addr;
   logic [63:0] tw_data;

   logic        bf_start;
   logic [7:0]  bf_idx1;
   logic [7:0]  bf_idx2;
   logic [63:0] bf_x1;
   logic [63:0] bf_x2;
   logic [63:0] bf_tw;

   logic        bf_valid;
   logic [7:0]  bf_out_idx1;
   logic [7:0]  bf_out_idx2;
   logic [63:0] bf_y1;
   logic [63:0] bf_y2;

   logic        wr_en;
   logic [7:0]  wr_addr1;
   logic [7:0]  wr_addr2;
   logic [63:0] wr_data1;
   logic [63:0] wr_data2;

   modport master (
      input  start, rd_data1, rd_data2, tw_data,
             bf_valid, bf_out_idx1, bf_out_idx2, bf_y1, bf_y2,
      output busy, done, rd_en, rd_addr1, rd_addr2, tw_addr,
             bf_start, bf_idx1, bf_idx2, bf_x1, bf_x2, bf_tw,
             wr_en, wr_addr1, wr_addr2, wr_data1, wr_data2
   );

   modport slave (
      output start, rd_data1, rd_data2, tw_data,
             bf_valid, bf_out_idx1, bf_out_idx2, bf_y1, bf_y2,
      input  busy, done, rd_en, rd_addr1, rd_addr2, tw_addr,
             bf_start, bf_idx1, bf_idx2, bf_x1, bf_x2, bf_tw,
             wr_en, wr_addr1, wr_addr2, wr_data1, wr_data2
   );
endinterface

// File: rtl/fft_bfly_ctrl.sv
// In-place radix-2 DIT FFT sequencer: issues one butterfly per cycle, writes results back
// by returned index and drains the butterfly pipeline between stages.
module fft_bfly_ctrl #(
   parameter int N_LOG2 = 3,
   parameter int LAT    = 3
) (
   input  logic            clk,
   input  logic            rst,
   fft_bfly_ctrl_if.master bus
);
   localparam int DATA_W = 64;
   localparam int ADDR_W = 8;
   localparam logic [6:0] B_LAST = 7'((1 << (N_LOG2 - 1)) - 1);
   localparam logic [2:0] S_LAST = 3'(N_LOG2 - 1);

   // The 4-bit outstanding counter must hold every butterfly in flight (LAT + 2 at most).
   if (N_LOG2 < 2 || N_LOG2 > 8 || LAT < 1 || LAT + 2 > 15) begin : g_param_err
      $error("fft_bfly_ctrl: illegal N_LOG2/LAT combination");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Lower operand index: group base (g * 2 * half) plus offset j inside the group.
   function automatic logic [ADDR_W-1:0] f_lo_idx(input logic [2:0] s, input logic [6:0] b);
      logic [ADDR_W-1:0] half_mask;
      logic [ADDR_W-1:0] grp;
      logic [ADDR_W-1:0] ofs;
      half_mask = (ADDR_W'(1) << s) - ADDR_W'(1);
      grp       = {1'b0, b} >> s;
      ofs       = {1'b0, b} & half_mask;
      return (grp << ({1'b0, s} + 4'd1)) | ofs;
   endfunction

   function automatic logic [ADDR_W-1:0] f_tw_idx(input logic [2:0] s, input logic [6:0] b);
      logic [ADDR_W-1:0] half_mask;
      logic [ADDR_W-1:0] ofs;
      half_mask = (ADDR_W'(1) << s) - ADDR_W'(1);
      ofs       = {1'b0, b} & half_mask;
      return ofs << (S_LAST - s);
   endfunction

   state_t              state_q;
   state_t              state_d;
   logic [2:0]          stg_q;
   logic [2:0]          stg_d;
   logic [6:0]          bcnt_q;
   logic [6:0]          bcnt_d;
   logic [3:0]          outst_cnt;

   logic                rd_go;
   logic [ADDR_W-1:0]   lo_idx;
   logic [ADDR_W-1:0]   hi_idx;
   logic [ADDR_W-1:0]   tw_idx;

   logic                vld_p1;
   logic [ADDR_W-1:0]   bf_idx1_p1;
   logic [ADDR_W-1:0]   bf_idx2_p1;
   logic                wr_vld_p1;
   logic [ADDR_W-1:0]   wr_addr1_p1;
   logic [ADDR_W-1:0]   wr_addr2_p1;
   logic [DATA_W-1:0]   wr_data1_p1;
   logic [DATA_W-1:0]   wr_data2_p1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         stg_q   <= '0;
         bcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         stg_q   <= stg_d;
         bcnt_q  <= bcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      stg_d   = stg_q;
      bcnt_d  = bcnt_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = ISSUE;
               stg_d   = '0;
               bcnt_d  = '0;
            end
         end
         ISSUE: begin
            bcnt_d = bcnt_q + 7'd1;
            if (bcnt_q == B_LAST) state_d = DRAIN;
         end
         DRAIN: begin
            // Next stage may only read once every result of this stage is back in RAM.
            if (outst_cnt == 4'd0) begin
               if (stg_q != S_LAST) begin
                  stg_d   = stg_q + 3'd1;
                  bcnt_d  = '0;
                  state_d = ISSUE;
               end else begin
                  state_d = DONE;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Stage p0: address generation and memory read request
   assign rd_go  = (state_q == ISSUE);
   assign lo_idx = f_lo_idx(stg_q, bcnt_q);
   assign hi_idx = lo_idx + (ADDR_W'(1) << stg_q);
   assign tw_idx = f_tw_idx(stg_q, bcnt_q);

   assign bus.rd_en    = rd_go;
   assign bus.rd_addr1 = rd_go ? lo_idx : '0;
   assign bus.rd_addr2 = rd_go ? hi_idx : '0;
   assign bus.tw_addr  = rd_go ? tw_idx : '0;
   assign bus.busy     = (state_q != IDLE);
   assign bus.done     = (state_q == DONE);

   // Saturating at zero lets stray results be written without corrupting the drain logic.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outst_cnt <= '0;
      end else if (rd_go && !wr_vld_p1) begin
         outst_cnt <= outst_cnt + 4'd1;
      end else if (!rd_go && wr_vld_p1 && outst_cnt != 4'd0) begin
         outst_cnt <= outst_cnt - 4'd1;
      end
   end

   // Stage p1: butterfly issue, aligned with the read data returned by the memories
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1     <= 1'b0;
         bf_idx1_p1 <= '0;
         bf_idx2_p1 <= '0;
      end else begin
         vld_p1     <= rd_go;
         bf_idx1_p1 <= bus.rd_addr1;
         bf_idx2_p1 <= bus.rd_addr2;
      end
   end

   assign bus.bf_start = vld_p1;
   assign bus.bf_idx1  = bf_idx1_p1;
   assign bus.bf_idx2  = bf_idx2_p1;
   assign bus.bf_x1    = bus.rd_data1;
   assign bus.bf_x2    = bus.rd_data2;
   assign bus.bf_tw    = bus.tw_data;

   // Stage p1 (return path): write-back of every butterfly result, whatever the state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_vld_p1   <= 1'b0;
         wr_addr1_p1 <= '0;
         wr_addr2_p1 <= '0;
         wr_data1_p1 <= '0;
         wr_data2_p1 <= '0;
      end else begin
         wr_vld_p1   <= bus.bf_valid;
         wr_addr1_p1 <= bus.bf_out_idx1;
         wr_addr2_p1 <= bus.bf_out_idx2;
         wr_data1_p1 <= bus.bf_y1;
         wr_data2_p1 <= bus.bf_y2;
      end
   end

   assign bus.wr_en    = wr_vld_p1;
   assign bus.wr_addr1 = wr_addr1_p1;
   assign bus.wr_addr2 = wr_addr2_p1;
   assign bus.wr_data1 = wr_data1_p1;
   assign bus.wr_data2 = wr_data2_p1;

endmodule

// File: tb/tb_fft_bfly_ctrl.sv
// Bench for fft_bfly_ctrl: RAM/ROM/butterfly models, cycle-exact schedule model and reference FFT.
`timescale 1ns/1ps
module tb_fft_bfly_ctrl;
   localparam int NL     = 3;
   localparam int LAT    = 3;
   localparam int N      = 1 << NL;
   localparam int STG    = N / 2 + LAT + 3;
   localparam int DONE_C = NL * STG + 1;
   localparam int LAST_C = DONE_C + 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int edges = 0;
   always @(posedge clk) edges <= edges + 1;

   int vecs = 0;
   int errs = 0;

   fft_bfly_ctrl_if bus();
   fft_bfly_ctrl #(.N_LOG2(NL), .LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] twf(input int k, input int n);
      real ang;
      int  re;
      int  im;
      ang = 2.0 * 3.14159265358979 * real'(k) / real'(n);
      re  = int'($cos(ang) * 256.0);
      im  = int'(-$sin(ang) * 256.0);
      return {im[31:0], re[31:0]};
   endfunction

   // Returns {y2, y1}: y1 = x1 + w*x2, y2 = x1 - w*x2 in Q24.8.
   function automatic logic [127:0] bfly(input logic [63:0] x1, input logic [63:0] x2, input logic [63:0] w);
      longint ar, ai, br, bi, wr, wi, pr, pi;
      ar = longint'($signed(x1[31:0]));
      ai = longint'($signed(x1[63:32]));
      br = longint'($signed(x2[31:0]));
      bi = longint'($signed(x2[63:32]));
      wr = longint'($signed(w[31:0]));
      wi = longint'($signed(w[63:32]));
      pr = (br * wr - bi * wi) >>> 8;
      pi = (br * wi + bi * wr) >>> 8;
      return {32'(ai - pi), 32'(ar - pr), 32'(ai + pi), 32'(ar + pr)};
   endfunction

   // ---------------- memory and butterfly models ----------------
   logic [63:0] ram      [N];
   logic [63:0] ram_init [N];
   logic [63:0] ref_ram  [N];
   logic        load = 1'b0;

   always_ff @(posedge clk) begin
      if (load) ram <= ram_init;
      else if (bus.wr_en) begin
         ram[bus.wr_addr1[NL-1:0]] <= bus.wr_data1;
         ram[bus.wr_addr2[NL-1:0]] <= bus.wr_data2;
      end
      if (bus.rd_en) begin
         bus.rd_data1 <= ram[bus.rd_addr1[NL-1:0]];
         bus.rd_data2 <= ram[bus.rd_addr2[NL-1:0]];
         bus.tw_data  <= twf(int'(bus.tw_addr), N);
      end
   end

   logic [LAT-1:0] bv;
   logic [15:0]    bi [LAT];
   logic [127:0]   by [LAT];
   logic           stray_vld = 1'b0;
   logic [7:0]     stray_i1 = '0, stray_i2 = '0;
   logic [63:0]    stray_y1 = '0, stray_y2 = '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) bv <= '0;
      else begin
         bv[0] <= bus.bf_start;
         bi[0] <= {bus.bf_idx1, bus.bf_idx2};
         by[0] <= bfly(bus.bf_x1, bus.bf_x2, bus.bf_tw);
         for (int k = 1; k < LAT; k++) begin
            bv[k] <= bv[k-1];
            bi[k] <= bi[k-1];
            by[k] <= by[k-1];
         end
      end
   end

   assign bus.bf_valid    = bv[LAT-1] | stray_vld;
   assign bus.bf_out_idx1 = stray_vld ? stray_i1 : bi[LAT-1][15:8];
   assign bus.bf_out_idx2 = stray_vld ? stray_i2 : bi[LAT-1][7:0];
   assign bus.bf_y1       = stray_vld ? stray_y1 : by[LAT-1][63:0];
   assign bus.bf_y2       = stray_vld ? stray_y2 : by[LAT-1][127:64];

   // ---------------- parameter sweep instances (timing only) ----------------
   localparam int SW_N [4] = '{2, 2, 8, 8};
   localparam int SW_L [4] = '{1, 5, 1, 5};
   logic sw_start = 1'b0;
   logic sw_clr   = 1'b0;
   int   sw_m     = 0;

   for (genvar gi = 0; gi < 4; gi++) begin : g_sw
      localparam int GN = SW_N[gi];
      localparam int GL = SW_L[gi];
      fft_bfly_ctrl_if sif();
      fft_bfly_ctrl #(.N_LOG2(GN), .LAT(GL)) u_dut (.clk(clk), .rst(rst), .bus(sif));
      logic [GL-1:0] vp;
      logic [15:0]   ip [GL];
      int done_cyc = -1;
      int done_cnt = 0;
      always_ff @(posedge clk or posedge rst) begin
         if (rst) vp <= '0;
         else begin
            vp[0] <= sif.bf_start;
            ip[0] <= {sif.bf_idx1, sif.bf_idx2};
            for (int k = 1; k < GL; k++) begin
               vp[k] <= vp[k-1];
               ip[k] <= ip[k-1];
            end
         end
      end
      always @(posedge clk) begin
         if (sw_clr) begin
            done_cyc <= -1;
            done_cnt <= 0;
         end else if (sif.done) begin
            done_cyc <= edges - sw_m;
            done_cnt <= done_cnt + 1;
         end
      end
      assign sif.start       = sw_start;
      assign sif.rd_data1    = '0;
      assign sif.rd_data2    = '0;
      assign sif.tw_data     = '0;
      assign sif.bf_valid    = vp[GL-1];
      assign sif.bf_out_idx1 = ip[GL-1][15:8];
      assign sif.bf_out_idx2 = ip[GL-1][7:0];
      assign sif.bf_y1       = '0;
      assign sif.bf_y2       = '0;
   end

   // ---------------- schedule model (cycle numbers relative to the start cycle) ----------------
   bit e_rd [64];
   bit e_bs [64];
   bit e_wr [64];
   int e_a1 [64], e_a2 [64], e_tw [64];
   int e_b1 [64], e_b2 [64];
   int e_w1 [64], e_w2 [64];

   task automatic build_model();
      for (int c = 0; c < 64; c++) begin
         e_rd[c] = 0; e_bs[c] = 0; e_wr[c] = 0;
      end
      for (int s = 0; s < NL; s++) begin
         int half = 1 << s;
         int t = 0;
         for (int k = 0; k < N; k += 2 * half) begin
            for (int j = 0; j < half; j++) begin
               int c = 1 + s * STG + t;
               t++;
               e_rd[c] = 1; e_a1[c] = k + j; e_a2[c] = k + j + half; e_tw[c] = j * (N / (2 * half));
               e_bs[c+1] = 1; e_b1[c+1] = k + j; e_b2[c+1] = k + j + half;
               e_wr[c+2+LAT] = 1; e_w1[c+2+LAT] = k + j; e_w2[c+2+LAT] = k + j + half;
            end
         end
      end
   endtask

   task automatic ref_fft();
      for (int i = 0; i < N; i++) ref_ram[i] = ram_init[i];
      for (int s = 0; s < NL; s++) begin
         int half = 1 << s;
         for (int k = 0; k < N; k += 2 * half) begin
            for (int j = 0; j < half; j++) begin
               logic [127:0] y;
               y = bfly(ref_ram[k+j], ref_ram[k+j+half], twf(j * (N / (2 * half)), N));
               ref_ram[k+j]      = y[63:0];
               ref_ram[k+j+half] = y[127:64];
            end
         end
      end
   endtask

   task automatic load_ram();
      @(negedge clk);
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic run_xform(input bit poke);
      load_ram();
      ref_fft();
      bus.start = 1'b1;
      for (int r = 1; r <= LAST_C; r++) begin
         @(negedge clk);
         bus.start = poke && (r == 10);
         chk($sformatf("rd_en@%0d", r),    64'(bus.rd_en),    64'(e_rd[r]));
         chk($sformatf("bf_start@%0d", r), 64'(bus.bf_start), 64'(e_bs[r]));
         chk($sformatf("wr_en@%0d", r),    64'(bus.wr_en),    64'(e_wr[r]));
         chk($sformatf("done@%0d", r),     64'(bus.done),     64'(r == DONE_C));
         chk($sformatf("busy@%0d", r),     64'(bus.busy),     64'(r <= DONE_C));
         if (e_rd[r]) begin
            chk($sformatf("rd_addr1@%0d", r), 64'(bus.rd_addr1), 64'(e_a1[r]));
            chk($sformatf("rd_addr2@%0d", r), 64'(bus.rd_addr2), 64'(e_a2[r]));
            chk($sformatf("tw_addr@%0d", r),  64'(bus.tw_addr),  64'(e_tw[r]));
         end
         if (e_bs[r]) begin
            chk($sformatf("bf_idx1@%0d", r), 64'(bus.bf_idx1), 64'(e_b1[r]));
            chk($sformatf("bf_idx2@%0d", r), 64'(bus.bf_idx2), 64'(e_b2[r]));
         end
         if (e_wr[r]) begin
            chk($sformatf("wr_addr1@%0d", r), 64'(bus.wr_addr1), 64'(e_w1[r]));
            chk($sformatf("wr_addr2@%0d", r), 64'(bus.wr_addr2), 64'(e_w2[r]));
         end
      end
      for (int i = 0; i < N; i++) chk($sformatf("ram[%0d]", i), ram[i], ref_ram[i]);
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_busy"},     64'(bus.busy),     64'(0));
      chk({tag, "_done"},     64'(bus.done),     64'(0));
      chk({tag, "_rd_en"},    64'(bus.rd_en),    64'(0));
      chk({tag, "_rd_addr1"}, 64'(bus.rd_addr1), 64'(0));
      chk({tag, "_rd_addr2"}, 64'(bus.rd_addr2), 64'(0));
      chk({tag, "_tw_addr"},  64'(bus.tw_addr),  64'(0));
      chk({tag, "_bf_start"}, 64'(bus.bf_start), 64'(0));
      chk({tag, "_bf_idx1"},  64'(bus.bf_idx1),  64'(0));
      chk({tag, "_wr_en"},    64'(bus.wr_en),    64'(0));
      chk({tag, "_wr_addr1"}, 64'(bus.wr_addr1), 64'(0));
      chk({tag, "_wr_data1"}, bus.wr_data1,      64'(0));
   endtask

   task automatic rand_init();
      for (int i = 0; i < N; i++) ram_init[i] = {$urandom() % 32'h10000, $urandom() % 32'h10000};
   endtask

   initial begin
      bit any_rd, any_wr, any_done, any_busy;
      int e_sw [4];
      bus.start = 1'b0;
      build_model();

      // reset state
      repeat (3) @(negedge clk);
      chk_idle_outputs("in_reset");
      chk("in_reset_outst", 64'(dut.outst_cnt), 64'(0));
      rst = 1'b0;
      @(negedge clk);
      chk_idle_outputs("after_reset");

      // impulse transform, with an ignored start pulse at cycle 10
      for (int i = 0; i < N; i++) ram_init[i] = '0;
      ram_init[0] = 64'h0000_0000_0000_0100;
      run_xform(1'b1);
      for (int i = 0; i < N; i++) chk($sformatf("impulse[%0d]", i), ram[i], 64'h0000_0000_0000_0100);

      // reset in the middle of stage 1
      rand_init();
      load_ram();
      bus.start = 1'b1;
      for (int r = 1; r <= 12; r++) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      rst = 1'b1;
      #1;
      chk_idle_outputs("midrst");
      @(negedge clk);
      rst = 1'b0;
      any_rd = 0; any_wr = 0; any_done = 0; any_busy = 0;
      repeat (40) begin
         @(negedge clk);
         any_rd   |= bus.rd_en;
         any_wr   |= bus.wr_en;
         any_done |= bus.done;
         any_busy |= bus.busy;
      end
      chk("midrst_no_rd",   64'(any_rd),   64'(0));
      chk("midrst_no_wr",   64'(any_wr),   64'(0));
      chk("midrst_no_done", 64'(any_done), 64'(0));
      chk("midrst_no_busy", 64'(any_busy), 64'(0));

      // fresh random transform after the reset
      rand_init();
      run_xform(1'b0);

      // stray result while idle
      for (int t = 0; t < 3; t++) begin
         logic [7:0]  i1, i2;
         logic [63:0] y1, y2;
         i1 = 8'($urandom_range(0, N - 1));
         i2 = 8'($urandom_range(0, N - 1));
         y1 = {$urandom(), $urandom()};
         y2 = {$urandom(), $urandom()};
         @(negedge clk);
         stray_i1 = i1; stray_i2 = i2; stray_y1 = y1; stray_y2 = y2;
         stray_vld = 1'b1;
         @(negedge clk);
         stray_vld = 1'b0;
         chk("stray_wr_en",    64'(bus.wr_en),    64'(1));
         chk("stray_wr_addr1", 64'(bus.wr_addr1), 64'(i1));
         chk("stray_wr_addr2", 64'(bus.wr_addr2), 64'(i2));
         chk("stray_wr_data1", bus.wr_data1,      y1);
         chk("stray_wr_data2", bus.wr_data2,      y2);
         chk("stray_busy",     64'(bus.busy),     64'(0));
         @(negedge clk);
         chk("stray_wr_off",   64'(bus.wr_en),     64'(0));
         chk("stray_outst",    64'(dut.outst_cnt), 64'(0));
         chk("stray_ram1",     ram[i1[NL-1:0]],    (i1 == i2) ? y2 : y1);
      end
      rand_init();
      run_xform(1'b0);

      // parameter sweep: done cycle formula
      for (int k = 0; k < 4; k++) e_sw[k] = SW_N[k] * ((1 << (SW_N[k] - 1)) + SW_L[k] + 3) + 1;
      @(negedge clk);
      sw_clr = 1'b1;
      @(negedge clk);
      sw_clr = 1'b0;
      sw_m = edges;
      sw_start = 1'b1;
      @(negedge clk);
      sw_start = 1'b0;
      for (int w = 0; w < 3000; w++) begin
         if (g_sw[0].done_cnt > 0 && g_sw[1].done_cnt > 0 && g_sw[2].done_cnt > 0 && g_sw[3].done_cnt > 0) break;
         @(negedge clk);
      end
      repeat (5) @(negedge clk);
      chk("sw_n2_l1_done_cyc", 64'(g_sw[0].done_cyc), 64'(e_sw[0]));
      chk("sw_n2_l5_done_cyc", 64'(g_sw[1].done_cyc), 64'(e_sw[1]));
      chk("sw_n8_l1_done_cyc", 64'(g_sw[2].done_cyc), 64'(e_sw[2]));
      chk("sw_n8_l5_done_cyc", 64'(g_sw[3].done_cyc), 64'(e_sw[3]));
      chk("sw_n2_l1_done_cnt", 64'(g_sw[0].done_cnt), 64'(1));
      chk("sw_n2_l5_done_cnt", 64'(g_sw[1].done_cnt), 64'(1));
      chk("sw_n8_l1_done_cnt", 64'(g_sw[2].done_cnt), 64'(1));
      chk("sw_n8_l5_done_cnt", 64'(g_sw[3].done_cnt), 64'(1));

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
